// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared types and constants for the product accumulator
package product_acc_pkg;
  localparam int PRODUCT_W     = 4;
  localparam int PRODUCT_MAX   = 9;
  localparam int FRAME_LEN_DEF = 4;
  localparam int ACC_W_DEF     = 8;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input and result output handshake bundle
interface product_accumulator_if import product_acc_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PRODUCT_W-1:0] product;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     sum;
  logic                 ovf;
  logic                 range_err;

  modport master (
    output in_valid, product, out_ready,
    input  in_ready, out_valid, sum, ovf, range_err
  );

  modport slave (
    input  in_valid, product, out_ready,
    output in_ready, out_valid, sum, ovf, range_err
  );
endinterface

// File: rtl/product_accumulator_sat_add.sv
// rtl/product_accumulator_sat_add.sv - saturating add of a product onto the accumulator
module sat_add import product_acc_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]     acc,
  input  logic [PRODUCT_W-1:0] operand,
  output logic [ACC_W-1:0]     result,
  output logic                 ovf
);
  logic [ACC_W:0] wide;

  assign wide   = {1'b0, acc} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, operand};
  assign ovf    = wide[ACC_W];
  // Operands are never negative, so clamping here keeps saturation sticky.
  assign result = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums fixed-length frames of products with saturation
module product_accumulator import product_acc_pkg::*; #(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   clear,
  product_accumulator_if.slave  bus
);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [PRODUCT_W-1:0] PMAX     = PRODUCT_W'(PRODUCT_MAX);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf_acc;
  logic             err_acc;
  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [ACC_W-1:0] add_res;
  logic             add_ovf;
  logic             beat_err;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc     (acc),
    .operand (bus.product),
    .result  (add_res),
    .ovf     (add_ovf)
  );

  assign beat_err = (bus.product > PMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_ACC;
      acc         <= '0;
      count       <= '0;
      ovf_acc     <= 1'b0;
      err_acc     <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state       <= ST_ACC;
      acc         <= '0;
      count       <= '0;
      ovf_acc     <= 1'b0;
      err_acc     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (bus.in_valid) begin
            if (count == LAST_IDX) begin
              sum_q       <= add_res;
              ovf_q       <= ovf_acc | add_ovf;
              err_q       <= err_acc | beat_err;
              acc         <= '0;
              count       <= '0;
              ovf_acc     <= 1'b0;
              err_acc     <= 1'b0;
              state       <= ST_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              acc     <= add_res;
              count   <= count + 1'b1;
              ovf_acc <= ovf_acc | add_ovf;
              err_acc <= err_acc | beat_err;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state       <= ST_ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.range_err = err_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized self-checking bench for product_accumulator
module tb_product_accumulator;
  localparam int FRAME_LEN = 4;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(8)) if8 ();
  product_accumulator_if #(.ACC_W(5)) if5 ();

  product_accumulator #(.FRAME_LEN(FRAME_LEN), .ACC_W(8)) dut8 (
    .clk (clk), .reset (reset), .clear (clear), .bus (if8.slave)
  );
  product_accumulator #(.FRAME_LEN(FRAME_LEN), .ACC_W(5)) dut5 (
    .clk (clk), .reset (reset), .clear (clear), .bus (if5.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: a frame is just a list of products; result is the plain total, clamped.
  int frame_q[$];
  bit holding;
  int exp_total;
  bit exp_err;

  function automatic int clamp(input int total, input int width);
    int mx = (1 << width) - 1;
    return (total > mx) ? mx : total;
  endfunction

  task automatic model_reset();
    frame_q.delete();
    holding   = 1'b0;
    exp_total = 0;
    exp_err   = 1'b0;
  endtask

  task automatic step(input bit clr, input bit iv, input int prod, input bit ordy);
    clear        = clr;
    if8.in_valid = iv;   if5.in_valid = iv;
    if8.product  = 4'(prod); if5.product = 4'(prod);
    if8.out_ready = ordy; if5.out_ready = ordy;
    @(posedge clk);
    if (clr) begin
      frame_q.delete();
      holding = 1'b0;
    end else if (holding) begin
      if (ordy) holding = 1'b0;
    end else if (iv) begin
      frame_q.push_back(prod);
      if (frame_q.size() == FRAME_LEN) begin
        exp_total = 0;
        exp_err   = 1'b0;
        foreach (frame_q[i]) begin
          exp_total += frame_q[i];
          if (frame_q[i] > 9) exp_err = 1'b1;
        end
        holding = 1'b1;
        frame_q.delete();
      end
    end
    #1;
    n_cmp += 4;
    if (if8.in_ready !== !holding) begin n_fail++; $display("FAIL in_ready8: got %b want %b", if8.in_ready, !holding); end
    if (if5.in_ready !== !holding) begin n_fail++; $display("FAIL in_ready5: got %b want %b", if5.in_ready, !holding); end
    if (if8.out_valid !== holding) begin n_fail++; $display("FAIL out_valid8: got %b want %b", if8.out_valid, holding); end
    if (if5.out_valid !== holding) begin n_fail++; $display("FAIL out_valid5: got %b want %b", if5.out_valid, holding); end
    if (holding) begin
      n_cmp += 6;
      if (int'(if8.sum) !== clamp(exp_total, 8)) begin n_fail++; $display("FAIL sum8: got %0d want %0d", if8.sum, clamp(exp_total, 8)); end
      if (int'(if5.sum) !== clamp(exp_total, 5)) begin n_fail++; $display("FAIL sum5: got %0d want %0d", if5.sum, clamp(exp_total, 5)); end
      if (if8.ovf !== (exp_total > 255)) begin n_fail++; $display("FAIL ovf8: got %b want %b", if8.ovf, exp_total > 255); end
      if (if5.ovf !== (exp_total > 31)) begin n_fail++; $display("FAIL ovf5: got %b want %b", if5.ovf, exp_total > 31); end
      if (if8.range_err !== exp_err) begin n_fail++; $display("FAIL range_err8: got %b want %b", if8.range_err, exp_err); end
      if (if5.range_err !== exp_err) begin n_fail++; $display("FAIL range_err5: got %b want %b", if5.range_err, exp_err); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear = 1'b0;
    if8.in_valid = 1'b0; if5.in_valid = 1'b0;
    if8.product = '0;    if5.product = '0;
    if8.out_ready = 1'b0; if5.out_ready = 1'b0;
    model_reset();
    #2;
    n_cmp += 4;
    if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", if8.out_valid); end
    if (if8.sum !== 8'd0) begin n_fail++; $display("FAIL reset_sum: got %0d want 0", if8.sum); end
    if (if8.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", if8.ovf); end
    if (if8.range_err !== 1'b0) begin n_fail++; $display("FAIL reset_range_err: got %b want 0", if8.range_err); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp += 2;
    if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", if8.in_ready); end
    if (if5.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", if5.out_valid); end
  endtask

  task automatic test_basic_frame();
    int prods[4] = '{9, 6, 0, 4};
    foreach (prods[i]) step(0, 1, prods[i], 1);
    n_cmp += 3;
    if (if8.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b want 1", if8.out_valid); end
    if (if8.sum !== 8'd19) begin n_fail++; $display("FAIL basic_sum: got %0d want 19", if8.sum); end
    if (if8.ovf !== 1'b0 || if8.range_err !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got %b%b want 00", if8.ovf, if8.range_err); end
    step(0, 1, 5, 1);
    step(0, 0, 0, 1);
  endtask

  task automatic test_saturation();
    repeat (4) step(0, 1, 9, 1);
    n_cmp += 2;
    if (if5.sum !== 5'd31 || if5.ovf !== 1'b1) begin n_fail++; $display("FAIL sat_sum5: got %0d/%b want 31/1", if5.sum, if5.ovf); end
    if (if8.sum !== 8'd36 || if8.ovf !== 1'b0) begin n_fail++; $display("FAIL sat_sum8: got %0d/%b want 36/0", if8.sum, if8.ovf); end
    step(0, 0, 0, 1);
    repeat (4) step(0, 1, 1, 0);
    n_cmp++;
    if (if5.sum !== 5'd4 || if5.ovf !== 1'b0) begin n_fail++; $display("FAIL sat_flag_clear: got %0d/%b want 4/0", if5.sum, if5.ovf); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) step(0, 1, i, 0);
    for (int c = 0; c < 5; c++) begin
      step(0, 1, $urandom_range(0, 15), 0);
      n_cmp++;
      if (if8.in_ready !== 1'b0 || if8.sum !== 8'd10) begin
        n_fail++; $display("FAIL bp_hold: got in_ready=%b sum=%0d want 0/10", if8.in_ready, if8.sum);
      end
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", if8.in_ready); end
  endtask

  task automatic test_clear();
    step(0, 1, 3, 0);
    step(0, 1, 3, 0);
    step(1, 1, 7, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, i, 0);
    n_cmp++;
    if (if8.sum !== 8'd10) begin n_fail++; $display("FAIL clear_sum: got %0d want 10", if8.sum); end
    step(1, 0, 0, 0);
    n_cmp++;
    if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hold: got %b want 0", if8.out_valid); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_gapped();
    bit vals[7] = '{1, 0, 0, 1, 1, 0, 1};
    foreach (vals[i]) step(0, vals[i], vals[i] ? 2 : 13, 1);
    n_cmp++;
    if (if8.sum !== 8'd8 || if8.out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_sum: got %0d/%b want 8/1", if8.sum, if8.out_valid); end
    step(0, 0, 0, 1);
    step(0, 1, 12, 0);
    repeat (3) step(0, 1, 1, 0);
    n_cmp++;
    if (if8.range_err !== 1'b1 || if8.sum !== 8'd15) begin n_fail++; $display("FAIL range_frame: got %b/%0d want 1/15", if8.range_err, if8.sum); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    step(0, 1, 7, 0);
    step(0, 1, 7, 0);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (if8.out_valid !== 1'b0 || if8.sum !== 8'd0) begin n_fail++; $display("FAIL areset_mid: got %b/%0d want 0/0", if8.out_valid, if8.sum); end
    model_reset();
    @(negedge clk) reset = 1'b1;
    repeat (4) step(0, 1, 1, 0);
    n_cmp++;
    if (if8.sum !== 8'd4) begin n_fail++; $display("FAIL areset_restart: got %0d want 4", if8.sum); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (if8.out_valid !== 1'b0 || if8.sum !== 8'd0 || if8.ovf !== 1'b0) begin
      n_fail++; $display("FAIL areset_hold: got %b/%0d/%b want 0/0/0", if8.out_valid, if8.sum, if8.ovf);
    end
    model_reset();
    @(negedge clk) reset = 1'b1;
    for (int i = 2; i <= 5; i++) step(0, 1, i, 0);
    n_cmp++;
    if (if8.sum !== 8'd14) begin n_fail++; $display("FAIL areset_after: got %0d want 14", if8.sum); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit clr  = ($urandom_range(0, 29) == 0);
      bit iv   = ($urandom_range(0, 3) != 0);
      int prod = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      bit ordy = $urandom_range(0, 1);
      step(clr, iv, prod, ordy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_saturation();
    test_backpressure();
    test_clear();
    test_gapped();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
